// File: rtl/pedestrian_request_conditioner.sv
// pedestrian_request_conditioner
// Conditions a bouncing, asynchronous pedestrian push-button into a clean
// request for a downstream light controller. The raw button is synchronised
// and debounced. Each accepted press raises WAIT_LAMP. The request is
// forwarded on BUTTON once the controller shows green. It then waits for one
// full green-off/green-on cycle before it accepts a new press.
//
// Build option: define MIN_GREEN_DWELL_EN to require MIN_GREEN_CYCLES of
// continuous green before a pending request is forwarded. Without it, any
// green forwards the request and MIN_GREEN_CYCLES has no effect.
module pedestrian_request_conditioner #(
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int MIN_GREEN_CYCLES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic RAW_BUTTON,
    input  logic GREEN_LIGHT,
    output logic BUTTON,
    output logic WAIT_LAMP
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        REQUEST = 2'd2,
        SERVING = 2'd3
    } state_t;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          level_prev_q, level_prev_d;
    logic [CW-1:0] count_q, count_d;
    logic          press_q, press_d;
    logic          green_met_s;
    state_t        state_q, state_d;
    logic          button_q, button_d;
    logic          wait_lamp_q, wait_lamp_d;

    // Synchroniser, debounce counter and registered rising-edge press detect.
    always_comb begin
        sync1_d      = RAW_BUTTON;
        sync2_d      = sync1_q;
        level_d      = level_q;
        count_d      = count_q;
        level_prev_d = level_q;
        press_d      = level_q & ~level_prev_q;
        if (sync2_q != level_q) begin
            if (count_q == DB_LAST) begin
                level_d = ~level_q;
                count_d = '0;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else begin
            count_d = '0;
        end
    end

    // Input conditioning registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            count_q      <= '0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            count_q      <= count_d;
            press_q      <= press_d;
        end
    end

`ifdef MIN_GREEN_DWELL_EN
    localparam int GW = $clog2(MIN_GREEN_CYCLES + 1);
    localparam logic [GW-1:0] GREEN_MAX = GW'(MIN_GREEN_CYCLES);

    logic [GW-1:0] green_timer_q, green_timer_d;

    // Green dwell timer: saturating count of consecutive green cycles.
    always_comb begin
        green_timer_d = green_timer_q;
        if (GREEN_LIGHT) begin
            if (green_timer_q != GREEN_MAX) begin
                green_timer_d = green_timer_q + GW'(1);
            end else begin
                green_timer_d = green_timer_q;
            end
        end else begin
            green_timer_d = '0;
        end
        green_met_s = GREEN_LIGHT && (green_timer_q == GREEN_MAX);
    end

    // Green dwell timer register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            green_timer_q <= '0;
        end else begin
            green_timer_q <= green_timer_d;
        end
    end
`else
    // Without the dwell feature any green lets a pending request through.
    always_comb begin
        green_met_s = GREEN_LIGHT;
    end
`endif

    // Request FSM next state. Presses outside IDLE are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (press_q) begin
                    state_d = PENDING;
                end else begin
                    state_d = IDLE;
                end
            end
            PENDING: begin
                if (green_met_s) begin
                    state_d = REQUEST;
                end else begin
                    state_d = PENDING;
                end
            end
            REQUEST: begin
                if (!GREEN_LIGHT) begin
                    state_d = SERVING;
                end else begin
                    state_d = REQUEST;
                end
            end
            SERVING: begin
                if (GREEN_LIGHT) begin
                    state_d = IDLE;
                end else begin
                    state_d = SERVING;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        button_d    = (state_d == REQUEST);
        wait_lamp_d = (state_d == PENDING) || (state_d == REQUEST);
    end

    // FSM state and output registers. The outputs always track the
    // registered state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            button_q    <= 1'b0;
            wait_lamp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            button_q    <= button_d;
            wait_lamp_q <= wait_lamp_d;
        end
    end

    assign BUTTON    = button_q;
    assign WAIT_LAMP = wait_lamp_q;

endmodule

// File: tb/tb_pedestrian_request_conditioner.sv
// Directed scoreboard bench for pedestrian_request_conditioner (default
// parameters). Each step drives the inputs and pushes the expected outputs.
// After the next rising edge it pops the expected outputs and compares them.
module tb_pedestrian_request_conditioner;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic RAW_BUTTON = 1'b0;
    logic GREEN_LIGHT = 1'b0;
    logic BUTTON;
    logic WAIT_LAMP;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        logic  button;
        logic  wait_lamp;
    } exp_t;

    exp_t sb_q[$];

`ifdef MIN_GREEN_DWELL_EN
    localparam int GREEN_LAT = 9;
`else
    localparam int GREEN_LAT = 1;
`endif

    pedestrian_request_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .MIN_GREEN_CYCLES(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .RAW_BUTTON (RAW_BUTTON),
        .GREEN_LIGHT(GREEN_LIGHT),
        .BUTTON     (BUTTON),
        .WAIT_LAMP  (WAIT_LAMP)
    );

    always #5 clock = ~clock;

    // Stops a runaway simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic compare_front();
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        assert (BUTTON === e.button) else begin
            errors++;
            $error("FAIL %s BUTTON: observed %b expected %b", e.tag, BUTTON, e.button);
        end
        checks++;
        assert (WAIT_LAMP === e.wait_lamp) else begin
            errors++;
            $error("FAIL %s WAIT_LAMP: observed %b expected %b", e.tag, WAIT_LAMP, e.wait_lamp);
        end
    endtask

    // Drive inputs, clock one edge, check outputs shortly after the edge.
    task automatic step(input logic raw, input logic grn, input logic exp_b,
                        input logic exp_w, input string tag);
        exp_t e;
        RAW_BUTTON  = raw;
        GREEN_LIGHT = grn;
        e.tag = tag;
        e.button = exp_b;
        e.wait_lamp = exp_w;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        compare_front();
    endtask

    // Check outputs at the current time, without a clock edge.
    task automatic check_now(input logic exp_b, input logic exp_w, input string tag);
        exp_t e;
        e.tag = tag;
        e.button = exp_b;
        e.wait_lamp = exp_w;
        sb_q.push_back(e);
        compare_front();
    endtask

    initial begin
        // Reset state.
        #2;
        check_now(1'b0, 1'b0, "reset_async");
        repeat (3) @(posedge clock);
        #1;
        check_now(1'b0, 1'b0, "reset_held");
        reset = 1'b0;

        // Steady press with green on: WAIT_LAMP after edge 7, BUTTON after edge 8.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, (i >= 8), (i >= 7), $sformatf("steady_press_e%0d", i));
        end

        // Green drops in REQUEST, so the block moves to SERVING.
        step(1'b1, 1'b0, 1'b0, 1'b0, "serving_enter");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "serving_release");
        // A second press while green is off is discarded.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "serving_press_ignored");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "serving_release2");
        // Green returns, so the block goes back to IDLE with nothing queued.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, "back_to_idle");

        // Glitches shorter than the debounce window: five 3-cycle pulses.
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, $sformatf("glitch_hi_p%0d", p));
            for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0, $sformatf("glitch_lo_p%0d", p));
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, "glitch_settle");

        // Press accepted while red, then green rises; forwarding latency depends on build.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "red_idle");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, (i >= 7), $sformatf("red_press_e%0d", i));
        end
        for (int i = 1; i <= GREEN_LAT + 2; i++) begin
            step(1'b1, 1'b1, (i >= GREEN_LAT), 1'b1, $sformatf("green_dwell_e%0d", i));
        end

        // Release the button while in REQUEST; the request is held.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b1, "request_hold");

        // Asynchronous reset mid-request drops the outputs without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        check_now(1'b0, 1'b0, "reset_mid_request");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0, "post_reset_quiet");

        checks++;
        assert (sb_q.size() === 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0d entries expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pedestrian_request_conditioner.md
PEDESTRIAN_REQUEST_CONDITIONER -- requirements
Module: pedestrian_request_conditioner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed below, clock and reset first.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 RAW_BUTTON  input  1  pedestrian push-button, asynchronous to clock, may bounce.
REQ-005 GREEN_LIGHT  input  1  feedback from the downstream light controller's green output.
REQ-006 BUTTON  output  1  request level driven into the light controller's BUTTON input.
REQ-007 WAIT_LAMP  output  1  pedestrian "request registered" indicator.
REQ-008 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a level change (legal range >= 1).
REQ-009 Parameter MIN_GREEN_CYCLES, default 8: minimum green dwell before a request is forwarded (legal range >= 1).

Function
REQ-010 RAW_BUTTON SHALL pass through a 2-flop synchroniser before any other use.
REQ-011 Debouncer SHALL count consecutive cycles where the synchronised input differs from the debounced level; on reaching DEBOUNCE_CYCLES the debounced level flips and the count clears; any cycle of agreement clears the count.
REQ-012 A press event SHALL be the single-cycle rising edge of the debounced level; falling edges generate no event.
REQ-013 Green timer SHALL count cycles with GREEN_LIGHT=1, saturating at MIN_GREEN_CYCLES, and clear to 0 on any cycle with GREEN_LIGHT=0.
REQ-014 FSM states SHALL be IDLE, PENDING, REQUEST and SERVING.
REQ-015 IDLE: press event -> PENDING; otherwise stay.
REQ-016 PENDING: GREEN_LIGHT=1 and green timer = MIN_GREEN_CYCLES -> REQUEST; otherwise stay.
REQ-017 REQUEST: GREEN_LIGHT=0 -> SERVING; otherwise stay.
REQ-018 SERVING: GREEN_LIGHT=1 -> IDLE; otherwise stay.
REQ-019 Press events in PENDING, REQUEST or SERVING SHALL be discarded, never queued.
REQ-020 Outputs SHALL be Moore decodes of the registered state: BUTTON=1 only in REQUEST; WAIT_LAMP=1 in PENDING and REQUEST.
REQ-021 With RAW_BUTTON held steady high, WAIT_LAMP SHALL rise DEBOUNCE_CYCLES+3 rising edges after the first edge sampling RAW_BUTTON high.
REQ-022 A press event and GREEN_LIGHT meeting the timer in the same cycle in IDLE SHALL move only to PENDING; REQUEST follows one edge later.
REQ-023 Glitches on RAW_BUTTON shorter than DEBOUNCE_CYCLES synchronised cycles SHALL produce no press event.

Reset
REQ-024 Reset assertion SHALL immediately force: state IDLE, synchroniser flops 0, debounced level 0, debounce count 0, green timer 0, BUTTON=0, WAIT_LAMP=0.
REQ-025 Reset asserted mid-request SHALL drop the pending or forwarded request; no press event SHALL be generated on release while RAW_BUTTON is already low.

Configuration
REQ-026 Macro MIN_GREEN_DWELL_EN SHALL select the minimum-green feature.
REQ-027 With MIN_GREEN_DWELL_EN defined: green timer and the PENDING condition of REQ-016 SHALL be implemented as specified.
REQ-028 Without MIN_GREEN_DWELL_EN: green timer SHALL be omitted; PENDING -> REQUEST on GREEN_LIGHT=1 alone; MIN_GREEN_CYCLES SHALL be ignored.

Verification
REQ-029 Defaults, GREEN_LIGHT=1 for 20 cycles, RAW_BUTTON high from edge 0 -> WAIT_LAMP=1 after edge 7; BUTTON=1 one edge later.
REQ-030 RAW_BUTTON pulses high for 3 cycles, repeated 5 times with 2-cycle gaps -> WAIT_LAMP and BUTTON stay 0 throughout.
REQ-031 MIN_GREEN_DWELL_EN defined, GREEN_LIGHT rises at edge 10, accepted press at edge 11 -> BUTTON stays 0 until green timer reaches 8, then BUTTON=1 at the following edge; without the macro, BUTTON=1 one edge after PENDING.
REQ-032 In REQUEST, GREEN_LIGHT drops -> next edge BUTTON=0, WAIT_LAMP=0 (SERVING); second press while GREEN_LIGHT=0 -> ignored; GREEN_LIGHT returns -> IDLE, outputs 0.
REQ-033 Reset pulsed while in REQUEST with RAW_BUTTON low -> BUTTON and WAIT_LAMP 0 immediately without a clock edge; after release, no output activity for 20 cycles.
